// File: rtl/tpu_sequencer.sv
// tpu_sequencer
// Instruction sequencer for the systolic-array TPU. One instruction is
// accepted per valid/ready handshake and expanded into a multi-cycle
// sequence of memory strobes, datapath enables and addresses.
//
// Instruction layout: {opcode, ADDRA, ADDRB}, opcode in the MSBs.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   instruction    instruction word, sampled only in the accept cycle
//   inst_valid     instruction present
//   inst_ready     sequencer can accept (state is S_IDLE)
//   flag           busy (state is S_EXEC)
//   err            sticky illegal-opcode flag, cleared by reset
//   read_ub, write_ub, read_wb, write_wb, read_acc, write_acc
//                  memory strobes
//   data_fifo_en, weight_fifo_en, mm_en, acc_en
//                  datapath enables
//   addra          write / accumulator address
//   addrb          read address
//
// Optional feature (macro CU_PERF_CNT_EN):
//   perf_inst_cnt  32-bit count of accepted instructions
//   perf_busy_cnt  32-bit count of cycles with flag=1
module tpu_sequencer #(
  parameter int OPCODE_BITS = 4,
  parameter int ADDR_BITS   = 8,
  parameter int INST_BITS   = OPCODE_BITS + 2*ADDR_BITS,
  parameter int ARRAY_DIM   = 16,
  parameter int MM_LATENCY  = 2*ARRAY_DIM
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [INST_BITS-1:0] instruction,
  input  logic                 inst_valid,
  output logic                 inst_ready,
  output logic                 flag,
  output logic                 err,
  output logic                 read_ub,
  output logic                 write_ub,
  output logic                 read_wb,
  output logic                 write_wb,
  output logic                 read_acc,
  output logic                 write_acc,
  output logic                 data_fifo_en,
  output logic                 weight_fifo_en,
  output logic                 mm_en,
  output logic                 acc_en,
`ifdef CU_PERF_CNT_EN
  output logic [31:0]          perf_inst_cnt,
  output logic [31:0]          perf_busy_cnt,
`endif
  output logic [ADDR_BITS-1:0] addra,
  output logic [ADDR_BITS-1:0] addrb
);

  localparam int KW = $clog2(MM_LATENCY + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EXEC = 1'b1;

  localparam logic [OPCODE_BITS-1:0] OP_IDLE         = OPCODE_BITS'(0);
  localparam logic [OPCODE_BITS-1:0] OP_WRITE_DATA   = OPCODE_BITS'(1);
  localparam logic [OPCODE_BITS-1:0] OP_WRITE_WEIGHT = OPCODE_BITS'(2);
  localparam logic [OPCODE_BITS-1:0] OP_LOAD_DATA    = OPCODE_BITS'(3);
  localparam logic [OPCODE_BITS-1:0] OP_LOAD_WEIGHT  = OPCODE_BITS'(4);
  localparam logic [OPCODE_BITS-1:0] OP_MAT_MUL      = OPCODE_BITS'(5);
  localparam logic [OPCODE_BITS-1:0] OP_MAT_MUL_ACC  = OPCODE_BITS'(6);

  // First k of a multiply at which results start draining to the accumulators.
  localparam logic [KW-1:0] ACC_START = KW'(MM_LATENCY - ARRAY_DIM);

  logic [0:0]           state;
  logic [KW-1:0]        k;
  logic [KW-1:0]        last_k;
  logic [INST_BITS-1:0] inst_q;
  logic [OPCODE_BITS-1:0] op;
  logic [OPCODE_BITS-1:0] new_op;
  logic [ADDR_BITS-1:0] field_a;
  logic [ADDR_BITS-1:0] field_b;

  assign op      = inst_q[INST_BITS-1 -: OPCODE_BITS];
  assign field_a = inst_q[2*ADDR_BITS-1 -: ADDR_BITS];
  assign field_b = inst_q[ADDR_BITS-1:0];
  assign new_op  = instruction[INST_BITS-1 -: OPCODE_BITS];

  assign inst_ready = (state == S_IDLE);
  assign flag       = (state == S_EXEC);

  // Final k value of the latched instruction; every unlisted opcode is one cycle.
  always_comb begin
    last_k = '0;
    case (op)
      OP_LOAD_WEIGHT: last_k = KW'(ARRAY_DIM - 1);
      OP_MAT_MUL,
      OP_MAT_MUL_ACC: last_k = KW'(MM_LATENCY - 1);
      default:        last_k = '0;
    endcase
  end

  // err is raised at the accept edge of an illegal opcode so it is already
  // visible while that instruction occupies its single EXEC cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      k      <= '0;
      inst_q <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (inst_valid) begin
            inst_q <= instruction;
            k      <= '0;
            state  <= S_EXEC;
            if (new_op > OP_MAT_MUL_ACC) err <= 1'b1;
          end
        end
        default: begin
          if (k == last_k) begin
            state <= S_IDLE;
            k     <= '0;
          end else begin
            k <= k + KW'(1);
          end
        end
      endcase
    end
  end

  // Outputs decode only from state, k and the latched instruction.
  always_comb begin
    read_ub        = 1'b0;
    write_ub       = 1'b0;
    read_wb        = 1'b0;
    write_wb       = 1'b0;
    read_acc       = 1'b0;
    write_acc      = 1'b0;
    data_fifo_en   = 1'b0;
    weight_fifo_en = 1'b0;
    mm_en          = 1'b0;
    acc_en         = 1'b0;
    addra          = '0;
    addrb          = '0;
    if (state == S_EXEC) begin
      case (op)
        OP_WRITE_DATA: begin
          write_ub = 1'b1;
          addra    = field_a;
        end
        OP_WRITE_WEIGHT: begin
          write_wb = 1'b1;
          addra    = field_a;
        end
        OP_LOAD_DATA: begin
          read_ub      = 1'b1;
          data_fifo_en = 1'b1;
          addrb        = field_b;
        end
        OP_LOAD_WEIGHT: begin
          read_wb        = 1'b1;
          weight_fifo_en = 1'b1;
          addrb          = field_b + ADDR_BITS'(k);
        end
        OP_MAT_MUL,
        OP_MAT_MUL_ACC: begin
          mm_en = 1'b1;
          if (k >= ACC_START) begin
            acc_en    = 1'b1;
            write_acc = 1'b1;
            read_acc  = (op == OP_MAT_MUL_ACC);
            addra     = field_a + ADDR_BITS'(k - ACC_START);
          end
        end
        default: begin
          // OP_IDLE and illegal opcodes: one strobe-free cycle.
        end
      endcase
    end
  end

`ifdef CU_PERF_CNT_EN
  // Both counters wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_inst_cnt <= '0;
      perf_busy_cnt <= '0;
    end else begin
      if (inst_valid && inst_ready) perf_inst_cnt <= perf_inst_cnt + 32'd1;
      if (flag)                     perf_busy_cnt <= perf_busy_cnt + 32'd1;
    end
  end
`endif

endmodule
